// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared definitions for the program-counter sequencer.
//   cond_t   - 3-bit branch condition codes
//   state_t  - sequencer FSM states (RUN / HALTED)
//   pc_sel_t - next-pc source select
//   cond_true() - evaluates a condition code against a flag set
package pc_seq_pkg;

    typedef enum logic [2:0] {
        COND_NZ = 3'b000,   // Z=0
        COND_Z  = 3'b001,   // Z=1
        COND_GT = 3'b010,   // Z=0 & N=0
        COND_N  = 3'b011,   // N=1
        COND_GE = 3'b100,   // Z=1 | (Z=0 & N=0)
        COND_LE = 3'b101,   // N=1 | Z=1
        COND_V  = 3'b110,   // V=1
        COND_AL = 3'b111    // always
    } cond_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        SEL_SEQ    = 3'd0,
        SEL_BRANCH = 3'd1,
        SEL_CALL   = 3'd2,
        SEL_RET    = 3'd3,
        SEL_HOLD   = 3'd4
    } pc_sel_t;

    function automatic logic cond_true(input logic [2:0] cond,
                                       input logic z,
                                       input logic v,
                                       input logic n);
        logic res;
        res = 1'b0;
        case (cond)
            COND_NZ: res = !z;
            COND_Z:  res = z;
            COND_GT: res = !z && !n;
            COND_N:  res = n;
            COND_GE: res = z || (!z && !n);
            COND_LE: res = n || z;
            COND_V:  res = v;
            default: res = 1'b1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack.
//   clk, rst_n     - clock / asynchronous active-low reset
//   push, pop      - stack operations (pop wins if both asserted)
//   push_data      - address to push
//   top            - current top-of-stack (combinational read)
//   empty, full    - occupancy status
//   ovf, unf       - sticky overflow / underflow, cleared only by reset
// A push on a full stack overwrites the oldest entry; a pop on an empty
// stack leaves the count at zero and raises unf.
module pc_ras
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int RAS_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full,
    output logic              ovf,
    output logic              unf
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]  wp_reg;      // next write slot; top lives just below it
    logic [CNT_W-1:0]  cnt_reg;
    logic              ovf_reg;
    logic              unf_reg;
    logic [PTR_W-1:0]  wp_inc;
    logic [PTR_W-1:0]  wp_dec;
    logic              push_eff;

    // Explicit wrap so non-power-of-two depths stay circular.
    assign wp_inc   = (wp_reg == PTR_W'(RAS_DEPTH - 1)) ? '0 : wp_reg + PTR_W'(1);
    assign wp_dec   = (wp_reg == '0) ? PTR_W'(RAS_DEPTH - 1) : wp_reg - PTR_W'(1);
    assign push_eff = push && !pop;

    assign top   = mem[wp_dec];
    assign empty = (cnt_reg == '0);
    assign full  = (cnt_reg == CNT_W'(RAS_DEPTH));
    assign ovf   = ovf_reg;
    assign unf   = unf_reg;

    // Storage carries no reset; entries are only meaningful below the count.
    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem[wp_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_reg  <= '0;
            cnt_reg <= '0;
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
        end else if (pop) begin
            if (cnt_reg != '0) begin
                wp_reg  <= wp_dec;
                cnt_reg <= cnt_reg - CNT_W'(1);
            end else begin
                unf_reg <= 1'b1;
            end
        end else if (push_eff) begin
            wp_reg <= wp_inc;
            if (cnt_reg == CNT_W'(RAS_DEPTH)) begin
                ovf_reg <= 1'b1;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pc_seq_unit.sv
// pc_seq_unit: program-counter sequencer with branch, call/return and halt.
//   clk, rst_n                 - clock / asynchronous active-low reset
//   stall                      - freezes all state, control inputs ignored
//   branch, call, ret, halt    - decoded instruction class
//   cond, b_off, c_off         - branch condition, branch / call offsets
//   ret_addr_in                - register-sourced return address
//   set_zero, set_over         - flag load enables; alu_z/alu_v/alu_n values
//   pc, link_pc, hlt           - fetch address, pc+1, halted indicator
//   z_flag, v_flag, n_flag     - registered flags
//   ras_empty/full/ovf/unf     - return-address stack status
// Next-pc priority: halt > ret > call > branch > sequential.
module pc_seq_unit
    import pc_seq_pkg::*;
#(
    parameter int              ADDR_W    = 16,
    parameter int              RAS_DEPTH = 8,
    parameter int              RET_MODE  = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch,
    input  logic              call,
    input  logic              ret,
    input  logic              halt,
    input  logic [2:0]        cond,
    input  logic [ADDR_W-1:0] b_off,
    input  logic [ADDR_W-1:0] c_off,
    input  logic [ADDR_W-1:0] ret_addr_in,
    input  logic              set_zero,
    input  logic              set_over,
    input  logic              alu_z,
    input  logic              alu_v,
    input  logic              alu_n,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] link_pc,
    output logic              hlt,
    output logic              z_flag,
    output logic              v_flag,
    output logic              n_flag,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_ovf,
    output logic              ras_unf
);

    state_t            state_reg, state_next;
    pc_sel_t           sel;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic              z_reg, z_next;
    logic              v_reg, v_next;
    logic              n_reg, n_next;
    logic              ras_push, ras_pop;
    logic [ADDR_W-1:0] ras_top;
    logic [ADDR_W-1:0] ret_target;

    assign link_pc = pc_reg + ADDR_W'(1);
    assign pc      = pc_reg;
    assign hlt     = (state_reg == ST_HALTED);
    assign z_flag  = z_reg;
    assign v_flag  = v_reg;
    assign n_flag  = n_reg;

    // An empty stack (always the case in register-return mode) falls back
    // to the register-sourced address.
    assign ret_target = ras_empty ? ret_addr_in : ras_top;

    generate
        if (RET_MODE == 1) begin : g_ras
            pc_ras #(
                .ADDR_W    (ADDR_W),
                .RAS_DEPTH (RAS_DEPTH)
            ) u_ras (
                .clk       (clk),
                .rst_n     (rst_n),
                .push      (ras_push),
                .pop       (ras_pop),
                .push_data (link_pc),
                .top       (ras_top),
                .empty     (ras_empty),
                .full      (ras_full),
                .ovf       (ras_ovf),
                .unf       (ras_unf)
            );
        end else begin : g_no_ras
            assign ras_top   = '0;
            assign ras_empty = 1'b1;
            assign ras_full  = 1'b0;
            assign ras_ovf   = 1'b0;
            assign ras_unf   = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
            pc_reg    <= RESET_PC;
            z_reg     <= 1'b0;
            v_reg     <= 1'b0;
            n_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            z_reg     <= z_next;
            v_reg     <= v_next;
            n_reg     <= n_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sel        = SEL_SEQ;
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
        z_next     = z_reg;
        v_next     = v_reg;
        n_next     = n_reg;

        if (state_reg == ST_HALTED || stall) begin
            sel = SEL_HOLD;
        end else begin
            if (set_zero) begin
                z_next = alu_z;
            end
            if (set_over) begin
                v_next = alu_v;
                n_next = alu_n;
            end
            if (halt) begin
                sel        = SEL_HOLD;
                state_next = ST_HALTED;
            end else if (ret) begin
                sel     = SEL_RET;
                ras_pop = (RET_MODE == 1);
            end else if (call) begin
                sel      = SEL_CALL;
                ras_push = (RET_MODE == 1);
            end else if (branch && cond_true(cond, z_reg, v_reg, n_reg)) begin
                sel = SEL_BRANCH;
            end
        end

        case (sel)
            SEL_BRANCH: pc_next = link_pc + b_off;
            SEL_CALL:   pc_next = link_pc + c_off;
            SEL_RET:    pc_next = ret_target;
            SEL_HOLD:   pc_next = pc_reg;
            default:    pc_next = link_pc;
        endcase
    end

endmodule
